// File: rtl/comb_pkg.sv
// comb_pkg: definitions shared by the Comb receive-side blocks.
//   state_t    : decoder FSM states (IDLE, DECODE, DONE)
//   COMB_W     : default data width
//   COMB_SUM_W : accumulator width; two extra bits so the sum absorbs a few words
//                before it saturates
package comb_pkg;

    localparam int COMB_W     = 8;
    localparam int COMB_SUM_W = COMB_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/comb_sat_acc.sv
// comb_sat_acc: saturating accumulator with synchronous clear and add enable.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear sum to 0 (when add_en is also set, sum takes add_val)
//   add_en     : add add_val to sum this cycle, clamping at all-ones
//   add_val    : DW-bit unsigned addend
//   sum        : SW-bit registered running sum
module comb_sat_acc #(
    parameter int DW = 8,
    parameter int SW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add_en,
    input  logic [DW-1:0] add_val,
    output logic [SW-1:0] sum
);

    // One spare bit catches the carry that signals overflow.
    logic [SW:0] total;

    assign total = {1'b0, sum} + (SW+1)'(add_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr && add_en) begin
            sum <= SW'(add_val);
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= total[SW] ? '1 : total[SW-1:0];
        end
    end

endmodule

// File: rtl/comb_gray_dec.sv
// comb_gray_dec: sequential reflected-Gray to binary decoder, one bit per clock, MSB first.
// Optional feature macro: COMB_GRAY_ACC_EN (adds sum_clr/out_sum saturating accumulator).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_gray is the Gray word
//   out_valid/out_ready : output handshake, out_bin is the result (0 when not valid)
//   sum_clr, out_sum    : accumulator clear and saturating sum of delivered results
//                         (COMB_GRAY_ACC_EN only)
module comb_gray_dec
    import comb_pkg::*;
#(
    parameter int WIDTH = COMB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_gray,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef COMB_GRAY_ACC_EN
    input  logic             sum_clr,
    output logic [WIDTH+1:0] out_sum,
`endif
    output logic [WIDTH-1:0] out_bin
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic [IW-1:0]    idx;
    logic             prev;     // result bit from the previous (higher) index
    logic             bit_nx;
    logic             accept;
    logic             deliver;

    assign accept  = in_valid && (state == IDLE);
    assign deliver = out_ready && (state == DONE);

    // prev is 0 at the MSB, so the first step reduces to bin[W-1] = g[W-1].
    assign bit_nx = gray_q[idx] ^ prev;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = DECODE;
            DECODE:  if (idx == '0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch word on acceptance, then resolve one bit per DECODE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= '0;
            bin_q  <= '0;
            idx    <= '0;
            prev   <= 1'b0;
        end else if (accept) begin
            gray_q <= in_gray;
            bin_q  <= '0;
            idx    <= IW'(WIDTH - 1);
            prev   <= 1'b0;
        end else if (state == DECODE) begin
            bin_q[idx] <= bit_nx;
            prev       <= bit_nx;
            idx        <= idx - 1'b1;
        end
    end

    // Outputs depend only on registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_bin   = (state == DONE) ? bin_q : '0;

`ifdef COMB_GRAY_ACC_EN
    comb_sat_acc #(
        .DW (WIDTH),
        .SW (WIDTH + 2)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sum_clr),
        .add_en  (deliver),
        .add_val (out_bin),
        .sum     (out_sum)
    );
`else
    // Without the accumulator the delivery strobe has no consumer.
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_comb_gray_dec.sv
// tb_comb_gray_dec: directed and random checks of comb_gray_dec against a parity-based
// Gray reference model; accumulator checks are built when COMB_GRAY_ACC_EN is defined.
module tb_comb_gray_dec;
    import comb_pkg::*;

    localparam int W      = COMB_W;
    localparam int SUMMAX = (1 << (W + 2)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_gray = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_bin;
`ifdef COMB_GRAY_ACC_EN
    logic         sum_clr = 1'b0;
    logic [W+1:0] out_sum;
`endif

    int passed = 0;
    int total  = 0;
    int model_sum = 0;

    always #5 clk = ~clk;

    comb_gray_dec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef COMB_GRAY_ACC_EN
        .sum_clr   (sum_clr),
        .out_sum   (out_sum),
`endif
        .out_bin   (out_bin)
    );

    // Binary bit i is the parity of Gray bits i and above.
    function automatic logic [W-1:0] ref_dec(input logic [W-1:0] g);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, hold for 'hold' cycles
    // under backpressure (with a competing in_valid), then deliver.
    task automatic deliver(input logic [W-1:0] g, input int hold, input bit clr);
        logic [W-1:0] exp;
        int           cyc;
        exp = ref_dec(g);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_gray  = g;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 0);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, W);
        chk("out_bin", 32'(out_bin), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_gray  = ~g;
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_bin", 32'(out_bin), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef COMB_GRAY_ACC_EN
        sum_clr = clr;
`endif
        tick();
        out_ready = 1'b0;
`ifdef COMB_GRAY_ACC_EN
        sum_clr = 1'b0;
        model_sum = clr ? int'(exp) : ((model_sum + int'(exp) > SUMMAX) ? SUMMAX : model_sum + int'(exp));
        chk("out_sum", 32'(out_sum), model_sum);
`else
        if (clr) model_sum = 0;
`endif
        chk("valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
        chk("bin_zero", 32'(out_bin), 0);
    endtask

    initial begin
        int acc_t[$];
        int cyc;
        bool_seen_t: begin end
        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_bin", 32'(out_bin), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
`ifdef COMB_GRAY_ACC_EN
        chk("rst_sum", 32'(out_sum), 0);
`endif

        // Directed decode values
        deliver(8'hC0, 0, 1'b0);
        chk("c0_ref", 32'(ref_dec(8'hC0)), 32'h80);
        deliver(8'hFF, 1, 1'b0);
        deliver(8'h0F, 0, 1'b0);
        deliver(8'h00, 2, 1'b0);
        // Backpressure for 5 cycles
        deliver(8'h5A, 5, 1'b0);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        in_gray   = 8'h0F;
        in_valid  = 1'b1;
        for (int c = 0; c < 35; c++) begin
            if (in_ready && in_valid) acc_t.push_back(c);
            if (out_valid) chk("b2b_bin", 32'(out_bin), 32'h0A);
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(acc_t.size() >= 3), 1);
        if (acc_t.size() >= 3) begin
            chk("b2b_gap1", acc_t[1] - acc_t[0], W + 2);
            chk("b2b_gap2", acc_t[2] - acc_t[1], W + 2);
        end
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drain", 32'(in_ready), 1);
        out_ready = 1'b0;

        // Reset in the middle of a decode
        in_gray  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_bin", 32'(out_bin), 0);
        tick();
        rst_n = 1'b1;
        model_sum = 0;
        cyc = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (out_valid === 1'b1) cyc++;
            tick();
        end
        out_ready = 1'b0;
        chk("midrst_no_result", cyc, 0);

        // Random words and backpressure
        for (int n = 0; n < 20; n++) begin
            deliver(W'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

`ifdef COMB_GRAY_ACC_EN
        // Standalone clear, then saturation and clear-with-delivery
        sum_clr = 1'b1;
        tick();
        sum_clr = 1'b0;
        model_sum = 0;
        chk("clr_only", 32'(out_sum), 0);
        for (int n = 0; n < 6; n++) deliver(8'hFF, 0, 1'b0);
        chk("sum_six", 32'(out_sum), 1020);
        deliver(8'hFF, 0, 1'b0);
        chk("sum_seven", 32'(out_sum), 1023);
        deliver(8'hFF, 0, 1'b0);
        chk("sum_eight", 32'(out_sum), 1023);
        deliver(8'hC0, 0, 1'b1);
        chk("sum_clr_deliver", 32'(out_sum), 128);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
